// File: rtl/inst_mem_resp.sv
// Instruction-memory responder for the fetch interface: synchronous-read word array,
// configurable wait states, fault detection and a word-write load port.
module inst_mem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ce,
  input  logic [31:0]                    i_inst_addr,
  input  logic                           i_flush,
  input  logic                           i_ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_addr,
  input  logic [31:0]                    i_ld_data,
  output logic [31:0]                    o_inst,
  output logic [31:0]                    o_inst_addr,
  output logic                           o_inst_valid,
  output logic                           o_fault,
  output logic                           o_fetch_stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;
  logic [31:0]   r_req_addr;
  logic [31:0]   w_rd_addr;
  logic          w_accept;
  logic          w_resp;
  logic          w_fault;
  logic [AW-1:0] w_idx;

  // Misaligned or beyond the array; compared on the full word address so high bits count.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  assign w_idx         = w_rd_addr[AW+1:2];
  assign w_fault       = addr_fault(w_rd_addr);
  assign o_fetch_stall = (r_state == ST_WAIT);

  // Next-state, wait counter and response strobe; flush wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_resp      = 1'b0;
    w_rd_addr   = r_req_addr;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_ce) begin
            w_accept  = 1'b1;
            w_rd_addr = i_inst_addr;
            if (WAIT_STATES == 0) begin
              w_resp = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT;
              w_cnt_nxt   = 3'(WAIT_STATES);
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd1) begin
            w_resp      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pending request address, captured only on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_addr <= 32'd0;
    end else if (w_accept) begin
      r_req_addr <= i_inst_addr;
    end
  end

  // Load port; the array has no reset.
  always_ff @(posedge i_clk) begin
    if (i_ld_we) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  // Registered response; a same-edge load write is not yet visible here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_inst       <= NOP_INST;
      o_inst_addr  <= 32'd0;
      o_inst_valid <= 1'b0;
      o_fault      <= 1'b0;
    end else begin
      o_inst_valid <= w_resp;
      o_fault      <= w_resp & w_fault;
      if (w_resp) begin
        o_inst      <= w_fault ? NOP_INST : r_mem[w_idx];
        o_inst_addr <= w_rd_addr;
      end
    end
  end

endmodule

// File: doc/inst_mem_resp.md
# inst_mem_resp

Instruction-memory responder for the fetch interface. It accepts `ce`/`inst_addr` from the IF stage and returns the addressed 32-bit instruction after a configurable number of wait states. While a fetch is pending it raises `fetch_stall`, which drives IF's `if_stall`. A word-write load port lets the testbench or boot logic program the array.

## Interface
- `DEPTH_WORDS`, 1024: instruction array size in 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 2: extra cycles per fetch, 0..7.
- `NOP_INST`, 32'h00000013: value returned on reset and on faults.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  fetch enable from IF.
- `inst_addr`  in  32  byte address of the fetch.
- `flush`  in  1  redirect in progress; discard the pending fetch and the current request.
- `ld_we`  in  1  load-port write strobe.
- `ld_addr`  in  log2(DEPTH_WORDS)  load-port word index.
- `ld_data`  in  32  load-port write data.
- `inst`  out  32  fetched instruction (registered).
- `inst_addr_o`  out  32  byte address belonging to `inst`.
- `inst_valid`  out  1  `inst` and `inst_addr_o` are valid this cycle; 1-cycle pulse per response.
- `fault`  out  1  qualifies `inst_valid`; the fetch was misaligned or out of range.
- `fetch_stall`  out  1  to IF `if_stall`; IF must hold `inst_addr`.

## Operation
- FSM states: IDLE and WAIT. A 3-bit counter `cnt` tracks wait states.
- Request acceptance: at an edge where `ce=1`, `flush=0` and state=IDLE, latch `inst_addr` into `req_addr`.
  - If `WAIT_STATES=0`: respond at the same edge. Set `inst` to mem[word], `inst_addr_o` to `inst_addr`, `inst_valid=1`. State stays IDLE.
  - Else: go to WAIT with `cnt=WAIT_STATES`.
- In WAIT, `cnt` decrements each edge. At the edge where `cnt==1`:
  - register the response from `req_addr`;
  - set `inst_valid=1`;
  - return to IDLE.
  - No new request is accepted at that edge.
- `fetch_stall` is decoded from the state: it equals (state==WAIT). It is never asserted in IDLE.
- Word index is `addr[log2(DEPTH)+1:2]`.
- Fault condition: `addr[1:0]!=0` or `addr[31:2]>=DEPTH_WORDS`. A faulting fetch has the same latency as a normal one and responds with `inst=NOP_INST`, `fault=1`. Otherwise `fault=0`.
- `inst_valid` and `fault` are 0 at every edge that registers no response.
- `inst` and `inst_addr_o` hold their last value when `inst_valid=0`.
- `flush=1` at an edge:
  - state goes to IDLE and `cnt=0`;
  - `inst_valid` goes to 0;
  - the request present that cycle is not accepted.
  - Flush overrides a response due at the same edge.
- `ce=0` in IDLE: no request, `inst_valid` goes to 0.
- Load port:
  - `ld_we=1` writes `ld_data` to mem[`ld_addr`] at the edge.
  - A read registered at the same edge returns the old word; later edges see the new word.
  - Writes are allowed in any state and have no effect on the FSM.
- Reset:
  - state=IDLE, `cnt=0`, `inst=NOP_INST`, `inst_addr_o=0`, `inst_valid=0`, `fault=0`, `fetch_stall=0`.
  - Array contents are not reset.
  - Reset during WAIT drops the pending fetch with no response.

## Timing
- Latency from the accepting edge to the `inst_valid` cycle is `WAIT_STATES+1` cycles when W>0, and 1 cycle when W=0.
- `fetch_stall` is high for exactly W cycles per accepted fetch. It goes high in the cycle after acceptance and low in the `inst_valid` cycle.
- Throughput:
  - W=0: one fetch per cycle.
  - W>0: one fetch per W+1 cycles.
  - The address IF advanced to at the accepting edge is held by the stall and accepted at the first IDLE edge. No address is skipped or duplicated.
- The array is a synchronous-read memory. Single write port plus single read port per cycle.

## Test plan
- **W=0, sequential fetch.** Load mem[0..3]=11,22,33,44. Set `ce=1` and addr 0,4,8,12 on consecutive cycles. Required: `inst_valid` is high on 4 consecutive cycles with `inst`=11,22,33,44, `inst_addr_o`=0,4,8,12, and `fetch_stall` never asserts.
- **W=2.** Fetch addr 8 (mem[2]=33). Required: `fetch_stall` high for exactly 2 cycles, then `inst_valid=1` with `inst=33` 3 cycles after acceptance. The next address, held by IF, is accepted on the following edge.
- **Flush during WAIT.** W=3; assert `flush` 1 cycle after accepting addr 4. Required: no `inst_valid` for addr 4, `fetch_stall` drops at the next cycle, and a fetch of addr 12 issued after the flush returns 44.
- **Faults.** Fetch addr 6 (misaligned), then addr 4×DEPTH_WORDS (out of range). Required: each response has `inst=0x00000013`, `fault=1`, and normal latency.
- **Load/read collision.** W=0; `ld_we` writes 0xDEAD to word 1 on the same edge that reads addr 4. Required: old value returned at that edge; the next fetch of addr 4 returns 0xDEAD.
- **Reset mid-WAIT.** W=2; assert `rst` in the first WAIT cycle. Required: the next cycle shows `inst_valid=0`, `fetch_stall=0`, `inst=0x00000013`, `inst_addr_o=0`, and a new fetch works normally.
